// File: rtl/alu_issue_queue_pkg.sv
// Shared constants for the ALU issue queue: tag-zero, operator codes and count-width helper.
package alu_issue_queue_pkg;

  localparam int unsigned TagZero = 0;

  localparam logic [5:0] OpAdd  = 6'd0;
  localparam logic [5:0] OpSub  = 6'd1;
  localparam logic [5:0] OpAnd  = 6'd2;
  localparam logic [5:0] OpOr   = 6'd3;
  localparam logic [5:0] OpXor  = 6'd4;
  localparam logic [5:0] OpSll  = 6'd5;
  localparam logic [5:0] OpSrl  = 6'd6;
  localparam logic [5:0] OpSra  = 6'd7;
  localparam logic [5:0] OpSlt  = 6'd8;
  localparam logic [5:0] OpSltu = 6'd9;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/alu_issue_queue_age_matrix.sv
// Allocation-order matrix for oldest-first issue; only used when RS_AGE_ORDER_EN is defined.
// age_q[i][j] set means entry i was allocated before entry j.
module rs_age_matrix
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  input  logic [IdxW-1:0]  alloc_idx_i,
  input  logic             issue_valid_i,
  input  logic [IdxW-1:0]  issue_idx_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] oldest_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) age_d[i] = age_q[i];
    if (issue_valid_i) begin
      age_d[issue_idx_i] = '0;
      for (int j = 0; j < int'(DEPTH); j++) age_d[j][issue_idx_i] = 1'b0;
    end
    // Stale bits of idle entries are harmless: both row and column are rewritten on allocate.
    if (alloc_valid_i) begin
      age_d[alloc_idx_i] = '0;
      for (int j = 0; j < int'(DEPTH); j++) age_d[j][alloc_idx_i] = (j != int'(alloc_idx_i));
    end
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (ready_i[j] && age_q[j][i]) blocked = 1'b1;
      end
      oldest_o[i] = ready_i[i] & ~blocked;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: allocate, CDB wakeup and single issue per cycle.
// Define RS_AGE_ORDER_EN for oldest-first issue; default is lowest-index-first.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CDB_N  = 2,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_rdy,
  input  logic                          in_flush,
  output logic                          out_capacity_full,
  output logic [count_width(DEPTH)-1:0] out_count,
  input  logic                          in_decoder_assign_enable,
  input  logic [OP_W-1:0]               in_decoder_type,
  input  logic [DATA_W-1:0]             in_decoder_imm,
  input  logic [ROB_W-1:0]              in_decoder_Qj,
  input  logic [ROB_W-1:0]              in_decoder_Qk,
  input  logic [DATA_W-1:0]             in_decoder_Vj,
  input  logic [DATA_W-1:0]             in_decoder_Vk,
  input  logic [ROB_W-1:0]              in_decoder_dest,
  input  logic [ADDR_W-1:0]             in_decoder_pc_addr,
  input  logic [CDB_N-1:0]              in_cdb_enable,
  input  logic [CDB_N*ROB_W-1:0]        in_cdb_reorder,
  input  logic [CDB_N*DATA_W-1:0]       in_cdb_result,
  input  logic                          in_alu_ready,
  output logic                          out_alu_enable,
  output logic [OP_W-1:0]               out_alu_type,
  output logic [ADDR_W-1:0]             out_alu_pc,
  output logic [DATA_W-1:0]             out_alu_imm,
  output logic [DATA_W-1:0]             out_alu_left_oprand,
  output logic [DATA_W-1:0]             out_alu_right_oprand,
  output logic [ROB_W-1:0]              out_alu_dest
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = count_width(DEPTH);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [OP_W-1:0]   type_q [DEPTH];
  logic [OP_W-1:0]   type_d [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] imm_d  [DEPTH];
  logic [ROB_W-1:0]  qj_q   [DEPTH];
  logic [ROB_W-1:0]  qj_d   [DEPTH];
  logic [ROB_W-1:0]  qk_q   [DEPTH];
  logic [ROB_W-1:0]  qk_d   [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vj_d   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [DATA_W-1:0] vk_d   [DEPTH];
  logic [ROB_W-1:0]  dest_q [DEPTH];
  logic [ROB_W-1:0]  dest_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];

  logic [CntW-1:0]   count_q, count_d;
  logic              alu_en_q, alu_en_d;
  logic [OP_W-1:0]   alu_type_q, alu_type_d;
  logic [ADDR_W-1:0] alu_pc_q, alu_pc_d;
  logic [DATA_W-1:0] alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0] alu_left_q, alu_left_d;
  logic [DATA_W-1:0] alu_right_q, alu_right_d;
  logic [ROB_W-1:0]  alu_dest_q, alu_dest_d;

  logic [DEPTH-1:0]  ready;
  logic              full;
  logic              alloc_valid;
  logic              issue_valid;
  logic [IdxW-1:0]   alloc_idx;
  logic [IdxW-1:0]   issue_idx;

  function automatic logic [IdxW-1:0] lowest_set(input logic [DEPTH-1:0] vec);
    lowest_set = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = IdxW'(i);
    end
  endfunction

  // Descending scan so the lowest matching channel is the last to write.
  function automatic logic [ROB_W+DATA_W-1:0] snoop(
    input logic [ROB_W-1:0]        tag,
    input logic [DATA_W-1:0]       val,
    input logic [CDB_N-1:0]        en,
    input logic [CDB_N*ROB_W-1:0]  tags,
    input logic [CDB_N*DATA_W-1:0] vals
  );
    snoop = {tag, val};
    if (tag != ROB_W'(TagZero)) begin
      for (int c = int'(CDB_N) - 1; c >= 0; c--) begin
        if (en[c] && tags[c*ROB_W +: ROB_W] == tag) begin
          snoop = {ROB_W'(TagZero), vals[c*DATA_W +: DATA_W]};
        end
      end
    end
  endfunction

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == ROB_W'(TagZero)) && (qk_q[i] == ROB_W'(TagZero));
    end
  end

  assign full        = &busy_q;
  assign alloc_idx   = lowest_set(~busy_q);
  assign alloc_valid = in_decoder_assign_enable & in_rdy & ~full & ~in_flush;
  assign issue_valid = in_rdy & in_alu_ready & (|ready) & ~in_flush;

`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0] oldest_sel;

  function automatic logic [IdxW-1:0] onehot_idx(input logic [DEPTH-1:0] vec);
    onehot_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vec[i]) onehot_idx = onehot_idx | IdxW'(i);
    end
  endfunction

  rs_age_matrix #(
    .DEPTH (DEPTH),
    .IdxW  (IdxW)
  ) u_age_matrix (
    .clk_i         (in_clk),
    .rst_i         (in_rst),
    .flush_i       (in_flush),
    .alloc_valid_i (alloc_valid),
    .alloc_idx_i   (alloc_idx),
    .issue_valid_i (issue_valid),
    .issue_idx_i   (issue_idx),
    .ready_i       (ready),
    .oldest_o      (oldest_sel)
  );

  assign issue_idx = onehot_idx(oldest_sel);
`else
  assign issue_idx = lowest_set(ready);
`endif

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      type_d[i] = type_q[i];
      imm_d[i]  = imm_q[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      vj_d[i]   = vj_q[i];
      vk_d[i]   = vk_q[i];
      dest_d[i] = dest_q[i];
      pc_d[i]   = pc_q[i];
    end

    if (in_rdy && !in_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (busy_q[i]) begin
          {qj_d[i], vj_d[i]} = snoop(qj_q[i], vj_q[i], in_cdb_enable, in_cdb_reorder,
                                     in_cdb_result);
          {qk_d[i], vk_d[i]} = snoop(qk_q[i], vk_q[i], in_cdb_enable, in_cdb_reorder,
                                     in_cdb_result);
        end
      end
    end

    if (issue_valid) busy_d[issue_idx] = 1'b0;

    if (alloc_valid) begin
      busy_d[alloc_idx] = 1'b1;
      type_d[alloc_idx] = in_decoder_type;
      imm_d[alloc_idx]  = in_decoder_imm;
      dest_d[alloc_idx] = in_decoder_dest;
      pc_d[alloc_idx]   = in_decoder_pc_addr;
      {qj_d[alloc_idx], vj_d[alloc_idx]} = snoop(in_decoder_Qj, in_decoder_Vj, in_cdb_enable,
                                                 in_cdb_reorder, in_cdb_result);
      {qk_d[alloc_idx], vk_d[alloc_idx]} = snoop(in_decoder_Qk, in_decoder_Vk, in_cdb_enable,
                                                 in_cdb_reorder, in_cdb_result);
    end

    if (in_flush) busy_d = '0;
  end

  always_comb begin
    alu_en_d    = issue_valid;
    alu_type_d  = alu_type_q;
    alu_pc_d    = alu_pc_q;
    alu_imm_d   = alu_imm_q;
    alu_left_d  = alu_left_q;
    alu_right_d = alu_right_q;
    alu_dest_d  = alu_dest_q;
    if (issue_valid) begin
      alu_type_d  = type_q[issue_idx];
      alu_pc_d    = pc_q[issue_idx];
      alu_imm_d   = imm_q[issue_idx];
      alu_left_d  = vj_q[issue_idx];
      alu_right_d = vk_q[issue_idx];
      alu_dest_d  = dest_q[issue_idx];
    end
    count_d = in_flush ? '0 : count_q + CntW'(alloc_valid) - CntW'(issue_valid);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      busy_q      <= '0;
      count_q     <= '0;
      alu_en_q    <= 1'b0;
      alu_type_q  <= '0;
      alu_pc_q    <= '0;
      alu_imm_q   <= '0;
      alu_left_q  <= '0;
      alu_right_q <= '0;
      alu_dest_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        type_q[i] <= '0;
        imm_q[i]  <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        dest_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      count_q     <= count_d;
      alu_en_q    <= alu_en_d;
      alu_type_q  <= alu_type_d;
      alu_pc_q    <= alu_pc_d;
      alu_imm_q   <= alu_imm_d;
      alu_left_q  <= alu_left_d;
      alu_right_q <= alu_right_d;
      alu_dest_q  <= alu_dest_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        type_q[i] <= type_d[i];
        imm_q[i]  <= imm_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        dest_q[i] <= dest_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  assign out_capacity_full    = full;
  assign out_count            = count_q;
  assign out_alu_enable       = alu_en_q;
  assign out_alu_type         = alu_type_q;
  assign out_alu_pc           = alu_pc_q;
  assign out_alu_imm          = alu_imm_q;
  assign out_alu_left_oprand  = alu_left_q;
  assign out_alu_right_oprand = alu_right_q;
  assign out_alu_dest         = alu_dest_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue; issue order expectations follow RS_AGE_ORDER_EN.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        full;
  logic [4:0]  count;
  logic        as_en;
  logic [5:0]  d_type;
  logic [31:0] d_imm, d_vj, d_vk, d_pc;
  logic [3:0]  d_qj, d_qk, d_dest;
  logic [1:0]  cdb_en;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_res;
  logic        alu_ready;
  logic        alu_en;
  logic [5:0]  alu_type;
  logic [31:0] alu_pc, alu_imm, alu_left, alu_right;
  logic [3:0]  alu_dest;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] left;
    logic [31:0] right;
    logic [3:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .in_clk                   (clk),
    .in_rst                   (rst),
    .in_rdy                   (rdy),
    .in_flush                 (flush),
    .out_capacity_full        (full),
    .out_count                (count),
    .in_decoder_assign_enable (as_en),
    .in_decoder_type          (d_type),
    .in_decoder_imm           (d_imm),
    .in_decoder_Qj            (d_qj),
    .in_decoder_Qk            (d_qk),
    .in_decoder_Vj            (d_vj),
    .in_decoder_Vk            (d_vk),
    .in_decoder_dest          (d_dest),
    .in_decoder_pc_addr       (d_pc),
    .in_cdb_enable            (cdb_en),
    .in_cdb_reorder           (cdb_tag),
    .in_cdb_result            (cdb_res),
    .in_alu_ready             (alu_ready),
    .out_alu_enable           (alu_en),
    .out_alu_type             (alu_type),
    .out_alu_pc               (alu_pc),
    .out_alu_imm              (alu_imm),
    .out_alu_left_oprand      (alu_left),
    .out_alu_right_oprand     (alu_right),
    .out_alu_dest             (alu_dest)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] imm, input logic [3:0] qj,
                        input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] dest, input logic [31:0] pc);
    as_en = 1'b1; d_type = op; d_imm = imm; d_qj = qj; d_qk = qk;
    d_vj = vj; d_vk = vk; d_dest = dest; d_pc = pc;
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] left, input logic [31:0] right,
                          input logic [3:0] dest);
    exp_t e;
    e.op = op; e.pc = pc; e.imm = imm; e.left = left; e.right = right; e.dest = dest;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    as_en = 1'b0; flush = 1'b0; cdb_en = '0;
  endtask

  // Monitor: every issue pulse consumes the next expected op.
  always @(negedge clk) begin
    if (!rst && alu_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL issue.unexpected: got pulse dest=%0d, expected none", alu_dest);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue.type", 64'(alu_type), 64'(mon_e.op));
        check("issue.pc", 64'(alu_pc), 64'(mon_e.pc));
        check("issue.imm", 64'(alu_imm), 64'(mon_e.imm));
        check("issue.left", 64'(alu_left), 64'(mon_e.left));
        check("issue.right", 64'(alu_right), 64'(mon_e.right));
        check("issue.dest", 64'(alu_dest), 64'(mon_e.dest));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; as_en = 1'b0; alu_ready = 1'b1;
    d_type = '0; d_imm = '0; d_qj = '0; d_qk = '0; d_vj = '0; d_vk = '0;
    d_dest = '0; d_pc = '0; cdb_en = '0; cdb_tag = '0; cdb_res = '0;
    tick();
    check("reset.enable", 64'(alu_en), 64'd0);
    check("reset.count", 64'(count), 64'd0);
    check("reset.full", 64'(full), 64'd0);
    check("reset.dest", 64'(alu_dest), 64'd0);
    check("reset.left", 64'(alu_left), 64'd0);
    rst = 1'b0;

    // Basic ready op: capture then issue one edge later.
    set_op(OpAdd, 32'h0, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 32'h100);
    push_exp(OpAdd, 32'h100, 32'h0, 32'd5, 32'd7, 4'd3);
    tick(); clr();
    check("basic.count1", 64'(count), 64'd1);
    check("basic.en_early", 64'(alu_en), 64'd0);
    tick();
    check("basic.en", 64'(alu_en), 64'd1);
    check("basic.count0", 64'(count), 64'd0);

    // Wake during assign via channel 1.
    set_op(OpSub, 32'h11, 4'd6, 4'd0, 32'h0, 32'd1, 4'd4, 32'h104);
    cdb_en = 2'b10; cdb_tag = {4'd6, 4'd2}; cdb_res = {32'h55, 32'h77};
    push_exp(OpSub, 32'h104, 32'h11, 32'h55, 32'd1, 4'd4);
    tick(); clr();
    tick();
    check("wake_assign.en", 64'(alu_en), 64'd1);

    // Same tag on both channels: channel 0 wins.
    set_op(OpXor, 32'h22, 4'd7, 4'd7, 32'h0, 32'h0, 4'd5, 32'h108);
    cdb_en = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_res = {32'hB0, 32'hA0};
    push_exp(OpXor, 32'h108, 32'h22, 32'hA0, 32'hA0, 4'd5);
    tick(); clr();
    tick();
    check("lowchan.en", 64'(alu_en), 64'd1);

    // Fill every entry waiting on tag 9.
    for (int i = 0; i < 16; i++) begin
      set_op(OpAnd, 32'(i), 4'd9, 4'd0, 32'hDEAD, 32'(i), 4'(i), 32'h200 + 32'(i * 4));
      push_exp(OpAnd, 32'h200 + 32'(i * 4), 32'(i), 32'h99, 32'(i), 4'(i));
      tick();
    end
    clr();
    check("fill.full", 64'(full), 64'd1);
    check("fill.count", 64'(count), 64'd16);
    cdb_en = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_res = {32'h0, 32'h99};
    tick(); clr();
    check("fill.wake_no_issue", 64'(alu_en), 64'd0);
    tick();
    check("fill.first_issue", 64'(alu_en), 64'd1);
    check("fill.full_drop", 64'(full), 64'd0);
    check("fill.count15", 64'(count), 64'd15);
    repeat (15) tick();
    check("fill.last_issue", 64'(alu_en), 64'd1);
    check("fill.count0", 64'(count), 64'd0);
    tick();
    check("fill.idle", 64'(alu_en), 64'd0);

    // Backpressure with three ready ops, then refill slot 0 after one issue.
    alu_ready = 1'b0;
    push_exp(OpOr, 32'h300, 32'h0, 32'd10, 32'd1, 4'd1);
    set_op(OpOr, 32'h0, 4'd0, 4'd0, 32'd10, 32'd1, 4'd1, 32'h300); tick();
    set_op(OpOr, 32'h0, 4'd0, 4'd0, 32'd20, 32'd2, 4'd2, 32'h304); tick();
    set_op(OpOr, 32'h0, 4'd0, 4'd0, 32'd30, 32'd3, 4'd3, 32'h308); tick();
    clr(); tick();
    check("bp.hold_en", 64'(alu_en), 64'd0);
    check("bp.count3", 64'(count), 64'd3);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    check("bp.one_issue", 64'(alu_en), 64'd1);
    check("bp.count2", 64'(count), 64'd2);
    set_op(OpOr, 32'h0, 4'd0, 4'd0, 32'd40, 32'd4, 4'd4, 32'h30C); tick(); clr();
    check("bp.count3b", 64'(count), 64'd3);
    tick();
    check("bp.hold_en2", 64'(alu_en), 64'd0);
`ifdef RS_AGE_ORDER_EN
    push_exp(OpOr, 32'h304, 32'h0, 32'd20, 32'd2, 4'd2);
    push_exp(OpOr, 32'h308, 32'h0, 32'd30, 32'd3, 4'd3);
    push_exp(OpOr, 32'h30C, 32'h0, 32'd40, 32'd4, 4'd4);
`else
    push_exp(OpOr, 32'h30C, 32'h0, 32'd40, 32'd4, 4'd4);
    push_exp(OpOr, 32'h304, 32'h0, 32'd20, 32'd2, 4'd2);
    push_exp(OpOr, 32'h308, 32'h0, 32'd30, 32'd3, 4'd3);
`endif
    alu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.burst_en", 64'(alu_en), 64'd1);
    end
    tick();
    check("bp.burst_end", 64'(alu_en), 64'd0);
    check("bp.count0", 64'(count), 64'd0);

    // in_rdy low blocks assign.
    rdy = 1'b0;
    set_op(OpSll, 32'h0, 4'd0, 4'd0, 32'd1, 32'd1, 4'd6, 32'h400);
    tick(); clr();
    check("rdy_low.count", 64'(count), 64'd0);
    check("rdy_low.en", 64'(alu_en), 64'd0);
    rdy = 1'b1;
    tick();
    check("rdy_low.no_issue", 64'(alu_en), 64'd0);

    // Flush with five waiting entries plus a same-cycle assign.
    for (int i = 0; i < 5; i++) begin
      set_op(OpSrl, 32'h0, 4'd12, 4'd0, 32'h0, 32'(i), 4'(i), 32'h500);
      tick();
    end
    clr();
    check("flush.pre_count", 64'(count), 64'd5);
    set_op(OpSra, 32'h0, 4'd0, 4'd0, 32'd1, 32'd2, 4'd9, 32'h600);
    flush = 1'b1;
    tick(); clr();
    check("flush.count", 64'(count), 64'd0);
    check("flush.en", 64'(alu_en), 64'd0);
    tick();
    check("flush.no_issue", 64'(alu_en), 64'd0);
    check("flush.full", 64'(full), 64'd0);
    set_op(OpSlt, 32'h33, 4'd0, 4'd0, 32'd8, 32'd9, 4'd10, 32'h700);
    push_exp(OpSlt, 32'h700, 32'h33, 32'd8, 32'd9, 4'd10);
    tick(); clr();
    check("flush.reassign_count", 64'(count), 64'd1);
    tick();
    check("flush.reassign_en", 64'(alu_en), 64'd1);

    // Asynchronous reset between edges while an issue pulse is high.
    alu_ready = 1'b0;
    set_op(OpSltu, 32'h0, 4'd0, 4'd0, 32'd3, 32'd4, 4'd11, 32'h800); tick();
    set_op(OpSltu, 32'h0, 4'd0, 4'd0, 32'd5, 32'd6, 4'd12, 32'h804); tick();
    clr();
    push_exp(OpSltu, 32'h800, 32'h0, 32'd3, 32'd4, 4'd11);
    alu_ready = 1'b1;
    tick();
    check("arst.pre_en", 64'(alu_en), 64'd1);
    check("arst.pre_count", 64'(count), 64'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst.en", 64'(alu_en), 64'd0);
    check("arst.count", 64'(count), 64'd0);
    check("arst.dest", 64'(alu_dest), 64'd0);
    rst = 1'b0;
    tick();
    check("arst.after_en", 64'(alu_en), 64'd0);
    check("arst.after_count", 64'(count), 64'd0);

    tick();
    check("scoreboard.empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
